// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Purpose  : RV32I instruction-decode stage. Holds the IF/ID pipeline
//             register, the 32x32 register file with write-back bypass, the
//             main/ALU control decoder, the immediate extender and the
//             load-use hazard detector.
//  Revision : 1.0  initial release
// ============================================================================
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    // Fetch stage
    input  logic [31:0] InstrF,
    input  logic [31:0] PCF,
    input  logic [31:0] PCPlus4F,
    // Execute stage feedback
    input  logic        PCSrcE,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ResultSrcE,
    // Write-back port
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    // Operands and instruction fields toward ID/EX
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [31:0] ImmExtD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [4:0]  RdD,
    // Control toward ID/EX
    output logic [2:0]  ALUControlD,
    output logic        ALUSrcD,
    output logic        MemWriteD,
    output logic        RegWriteD,
    output logic        BranchD,
    output logic        JumpD,
    output logic [1:0]  ResultSrcD,
    // Hazard control
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        IllegalD
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    localparam logic [1:0] c_RES_ALU = 2'b00;
    localparam logic [1:0] c_RES_MEM = 2'b01;
    localparam logic [1:0] c_RES_PC4 = 2'b10;

    localparam logic [31:0] c_RESET_PC4 = RESET_PC + 32'd4;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        r_valid;
    logic [31:0] r_regs [32];

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7b5;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;

    logic [2:0]  w_alu_sel;
    logic        w_alu_ok;

    logic [2:0]  w_alu_ctl;
    logic        w_alu_src;
    logic        w_mem_write;
    logic        w_reg_write;
    logic        w_branch;
    logic        w_jump;
    logic [1:0]  w_result_src;
    logic        w_illegal;
    logic [31:0] w_imm;

    logic        w_wb_en;
    logic        w_lw_stall;
    logic        w_stall;

    // ------------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------------
    assign w_opcode   = r_instr[6:0];
    assign w_funct3   = r_instr[14:12];
    assign w_funct7b5 = r_instr[30];
    assign w_rs1      = r_instr[19:15];
    assign w_rs2      = r_instr[24:20];
    assign w_rd       = r_instr[11:7];

    // ------------------------------------------------------------------------
    // Hazard detection. Rs2 is compared for every format, so an I-type whose
    // immediate bits happen to match RdE also stalls; that only costs a cycle.
    // A taken branch discards whatever sits in ID, so it overrides the stall.
    // ------------------------------------------------------------------------
    assign w_lw_stall = (ResultSrcE == c_RES_MEM) && (RdE != 5'd0) &&
                        ((RdE == w_rs1) || (RdE == w_rs2)) && r_valid;
    assign w_stall    = w_lw_stall && !PCSrcE;

    // IF/ID register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr    <= 32'd0;
            r_valid    <= 1'b0;
            r_pc       <= RESET_PC;
            r_pc_plus4 <= c_RESET_PC4;
        end else if (PCSrcE) begin
            // Squash the wrong-path instruction; the PCs are don't-care and held.
            r_instr    <= 32'd0;
            r_valid    <= 1'b0;
        end else if (!w_stall) begin
            r_instr    <= InstrF;
            r_valid    <= 1'b1;
            r_pc       <= PCF;
            r_pc_plus4 <= PCPlus4F;
        end
    end

    // ------------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------------
    assign w_wb_en = RegWriteW && (RdW != 5'd0);

    // Register array write; x0 is never written so it always reads zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_wb_en) begin
            r_regs[RdW] <= ResultW;
        end
    end

    // Combinational read with write-through bypass so a value written at the
    // end of this cycle is already seen by the instruction decoding now
    always_comb begin
        if (w_rs1 == 5'd0) begin
            RD1 = 32'd0;
        end else if (w_wb_en && (RdW == w_rs1)) begin
            RD1 = ResultW;
        end else begin
            RD1 = r_regs[w_rs1];
        end

        if (w_rs2 == 5'd0) begin
            RD2 = 32'd0;
        end else if (w_wb_en && (RdW == w_rs2)) begin
            RD2 = ResultW;
        end else begin
            RD2 = r_regs[w_rs2];
        end
    end

    // ------------------------------------------------------------------------
    // ALU operation for R-type / I-ALU. Bit 30 selects sub only for R-type
    // (opcode bit 5 set); in an I-type it is an immediate bit.
    // ------------------------------------------------------------------------
    always_comb begin
        w_alu_sel = c_ALU_ADD;
        w_alu_ok  = 1'b1;
        case (w_funct3)
            3'b000: w_alu_sel = (w_opcode[5] && w_funct7b5) ? c_ALU_SUB : c_ALU_ADD;
            3'b010: w_alu_sel = c_ALU_SLT;
            3'b110: w_alu_sel = c_ALU_OR;
            3'b111: w_alu_sel = c_ALU_AND;
            default: w_alu_ok = 1'b0;
        endcase
    end

    // Main decoder and immediate extender; an unsupported encoding yields no
    // side effects (all controls zero) and only raises IllegalD
    always_comb begin
        w_alu_ctl    = c_ALU_ADD;
        w_alu_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_result_src = c_RES_ALU;
        w_illegal    = 1'b0;
        w_imm        = 32'd0;

        if (r_valid) begin
            case (w_opcode)
                c_OP_LOAD: begin
                    w_illegal    = (w_funct3 != 3'b010);
                    w_alu_src    = 1'b1;
                    w_reg_write  = 1'b1;
                    w_result_src = c_RES_MEM;
                    w_alu_ctl    = c_ALU_ADD;
                    w_imm        = {{20{r_instr[31]}}, r_instr[31:20]};
                end
                c_OP_STORE: begin
                    w_illegal    = (w_funct3 != 3'b010);
                    w_alu_src    = 1'b1;
                    w_mem_write  = 1'b1;
                    w_alu_ctl    = c_ALU_ADD;
                    w_imm        = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
                end
                c_OP_RTYPE: begin
                    w_illegal    = !w_alu_ok;
                    w_reg_write  = 1'b1;
                    w_alu_ctl    = w_alu_sel;
                end
                c_OP_IALU: begin
                    w_illegal    = !w_alu_ok;
                    w_alu_src    = 1'b1;
                    w_reg_write  = 1'b1;
                    w_alu_ctl    = w_alu_sel;
                    w_imm        = {{20{r_instr[31]}}, r_instr[31:20]};
                end
                c_OP_BRANCH: begin
                    w_illegal    = (w_funct3 != 3'b000);
                    w_branch     = 1'b1;
                    w_alu_ctl    = c_ALU_SUB;
                    w_imm        = {{20{r_instr[31]}}, r_instr[7], r_instr[30:25],
                                    r_instr[11:8], 1'b0};
                end
                c_OP_JAL: begin
                    w_jump       = 1'b1;
                    w_reg_write  = 1'b1;
                    w_result_src = c_RES_PC4;
                    w_alu_ctl    = c_ALU_ADD;
                    w_imm        = {{12{r_instr[31]}}, r_instr[19:12], r_instr[20],
                                    r_instr[30:21], 1'b0};
                end
                default: begin
                    w_illegal    = 1'b1;
                end
            endcase

            if (w_illegal) begin
                w_alu_ctl    = c_ALU_ADD;
                w_alu_src    = 1'b0;
                w_mem_write  = 1'b0;
                w_reg_write  = 1'b0;
                w_branch     = 1'b0;
                w_jump       = 1'b0;
                w_result_src = c_RES_ALU;
                w_imm        = 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ImmExtD     = w_imm;
    assign PCD         = r_pc;
    assign PCPlus4D    = r_pc_plus4;
    assign Rs1D        = w_rs1;
    assign Rs2D        = w_rs2;
    assign RdD         = w_rd;
    assign ALUControlD = w_alu_ctl;
    assign ALUSrcD     = w_alu_src;
    assign MemWriteD   = w_mem_write;
    assign RegWriteD   = w_reg_write;
    assign BranchD     = w_branch;
    assign JumpD       = w_jump;
    assign ResultSrcD  = w_result_src;
    assign IllegalD    = w_illegal;
    assign StallF      = w_stall;
    assign StallD      = w_stall;
    assign FlushE      = w_lw_stall || PCSrcE;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_stage
//  Purpose  : Self-checking bench for id_stage: decode vector table plus
//             directed bypass, load-use, flush and reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        PCSrcE;
    logic [4:0]  RdE;
    logic [1:0]  ResultSrcE;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [31:0] RD1, RD2, ImmExtD, PCD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [2:0]  ALUControlD;
    logic        ALUSrcD, MemWriteD, RegWriteD, BranchD, JumpD;
    logic [1:0]  ResultSrcD;
    logic        StallF, StallD, FlushE, IllegalD;

    id_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .PCSrcE(PCSrcE), .RdE(RdE), .ResultSrcE(ResultSrcE),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .RD1(RD1), .RD2(RD2), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD),
        .RegWriteD(RegWriteD), .BranchD(BranchD), .JumpD(JumpD),
        .ResultSrcD(ResultSrcD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .IllegalD(IllegalD)
    );

    always #5 clk = ~clk;

    // {Illegal, ALUControl, ALUSrc, MemWrite, RegWrite, Branch, Jump, ResultSrc}
    logic [10:0] ctrl_act;
    logic [2:0]  haz_act;
    assign ctrl_act = {IllegalD, ALUControlD, ALUSrcD, MemWriteD, RegWriteD,
                       BranchD, JumpD, ResultSrcD};
    assign haz_act  = {StallF, StallD, FlushE};

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [10:0] ctrl;
        logic [31:0] imm;
        logic        chk_imm;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [10:0] mk(input logic ill, input logic [2:0] alu,
                                       input logic src, input logic mw, input logic rw,
                                       input logic br, input logic jmp,
                                       input logic [1:0] rs);
        return {ill, alu, src, mw, rw, br, jmp, rs};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADDI_N3 = 32'hFFD0_0293; // addi x5,x0,-3
    localparam logic [31:0] I_ADD_X7  = 32'h0003_80B3; // add  x1,x7,x0
    localparam logic [31:0] I_SUB     = 32'h4021_8233; // sub  x4,x3,x2
    localparam logic [31:0] I_OR      = 32'h0020_E333; // or   x6,x1,x2
    localparam logic [31:0] I_BEQ_N8  = 32'hFE20_8CE3; // beq  x1,x2,-8
    localparam logic [31:0] I_ILL7F   = 32'h0000_007F;

    initial begin
        vecs[0]  = '{I_ADDI_N3,    mk(0,3'b000,1,0,1,0,0,2'b00), 32'hFFFF_FFFD, 1, 5'd5};
        vecs[1]  = '{I_ADD_X7,     mk(0,3'b000,0,0,1,0,0,2'b00), 32'h0,         1, 5'd1};
        vecs[2]  = '{I_SUB,        mk(0,3'b001,0,0,1,0,0,2'b00), 32'h0,         1, 5'd4};
        vecs[3]  = '{32'h0020_A333, mk(0,3'b101,0,0,1,0,0,2'b00), 32'h0,        1, 5'd6};
        vecs[4]  = '{I_OR,         mk(0,3'b011,0,0,1,0,0,2'b00), 32'h0,         1, 5'd6};
        vecs[5]  = '{32'h0020_F333, mk(0,3'b010,0,0,1,0,0,2'b00), 32'h0,        1, 5'd6};
        vecs[6]  = '{32'h7FF0_E293, mk(0,3'b011,1,0,1,0,0,2'b00), 32'h0000_07FF, 1, 5'd5};
        vecs[7]  = '{32'h4000_0093, mk(0,3'b000,1,0,1,0,0,2'b00), 32'h0000_0400, 1, 5'd1};
        vecs[8]  = '{32'hFFF0_2113, mk(0,3'b101,1,0,1,0,0,2'b00), 32'hFFFF_FFFF, 1, 5'd2};
        vecs[9]  = '{32'h0081_2183, mk(0,3'b000,1,0,1,0,0,2'b01), 32'h0000_0008, 1, 5'd3};
        vecs[10] = '{32'hFE51_2E23, mk(0,3'b000,1,1,0,0,0,2'b00), 32'hFFFF_FFFC, 1, 5'd28};
        vecs[11] = '{I_BEQ_N8,     mk(0,3'b001,0,0,0,1,0,2'b00), 32'hFFFF_FFF8, 1, 5'd25};
        vecs[12] = '{32'h0010_00EF, mk(0,3'b000,0,0,1,0,1,2'b10), 32'h0000_0800, 1, 5'd1};
        vecs[13] = '{I_ILL7F,      mk(1,3'b000,0,0,0,0,0,2'b00), 32'h0,         0, 5'd0};
        vecs[14] = '{32'h0020_9333, mk(1,3'b000,0,0,0,0,0,2'b00), 32'h0,        0, 5'd6};
        vecs[15] = '{32'h0081_0183, mk(1,3'b000,0,0,0,0,0,2'b00), 32'h0,        0, 5'd3};
        vecs[16] = '{32'h0010_9093, mk(1,3'b000,0,0,0,0,0,2'b00), 32'h0,        0, 5'd1};

        // ---------------- reset state ----------------
        reset = 1'b1;
        InstrF = I_ADDI_N3; PCF = 32'h0000_0500; PCPlus4F = 32'h0000_0504;
        PCSrcE = 1'b0; RdE = 5'd0; ResultSrcE = 2'b00;
        RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'd0;
        tick();
        tick();
        chk("reset_ctrl",  {21'd0, ctrl_act}, 32'd0);
        chk("reset_imm",   ImmExtD, 32'd0);
        chk("reset_pcd",   PCD, RESET_PC);
        chk("reset_pc4",   PCPlus4D, RESET_PC + 32'd4);
        chk("reset_haz",   {29'd0, haz_act}, 32'd0);
        chk("reset_rd12",  RD1 | RD2, 32'd0);
        chk("reset_flds",  {17'd0, Rs1D, Rs2D, RdD}, 32'd0);
        reset = 1'b0;

        // ---------------- decode table ----------------
        for (int i = 0; i < 17; i++) begin
            InstrF   = vecs[i].instr;
            PCF      = 32'h0000_0200 + 32'(i) * 32'd4;
            PCPlus4F = PCF + 32'd4;
            tick();
            chk($sformatf("vec%0d_ctrl", i), {21'd0, ctrl_act}, {21'd0, vecs[i].ctrl});
            if (vecs[i].chk_imm)
                chk($sformatf("vec%0d_imm", i), ImmExtD, vecs[i].imm);
            chk($sformatf("vec%0d_rd", i), {27'd0, RdD}, {27'd0, vecs[i].rd});
            chk($sformatf("vec%0d_pcd", i), PCD, 32'h0000_0200 + 32'(i) * 32'd4);
        end

        // ---------------- write-back bypass ----------------
        InstrF = I_ADD_X7; PCF = 32'h0000_0280; PCPlus4F = 32'h0000_0284;
        tick();
        RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'hDEAD_BEEF;
        #1;
        chk("bypass_rd1", RD1, 32'hDEAD_BEEF);
        chk("bypass_rd2_x0", RD2, 32'd0);
        tick();
        RegWriteW = 1'b0;
        #1;
        chk("array_rd1", RD1, 32'hDEAD_BEEF);
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h1234_5678;
        #1;
        chk("x0_bypass", RD2, 32'd0);
        tick();
        RegWriteW = 1'b0;
        #1;
        chk("x0_array", RD2, 32'd0);
        InstrF = I_OR;
        tick();
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h0000_55AA;
        #1;
        chk("bypass_rd2", RD2, 32'h0000_55AA);
        chk("rd1_unwritten", RD1, 32'd0);
        tick();
        RegWriteW = 1'b0;

        // ---------------- load-use stall ----------------
        InstrF = I_SUB; PCF = 32'h0000_0300; PCPlus4F = 32'h0000_0304;
        tick();
        InstrF = I_ADDI_N3; PCF = 32'h0000_0304; PCPlus4F = 32'h0000_0308;
        ResultSrcE = 2'b01; RdE = 5'd0;
        #1;
        chk("lu_rde0", {29'd0, haz_act}, 32'd0);
        RdE = 5'd2;
        #1;
        chk("lu_rs2", {29'd0, haz_act}, 32'd7);
        ResultSrcE = 2'b00;
        #1;
        chk("lu_not_load", {29'd0, haz_act}, 32'd0);
        ResultSrcE = 2'b01; RdE = 5'd3;
        #1;
        chk("lu_rs1", {29'd0, haz_act}, 32'd7);
        tick();
        ResultSrcE = 2'b00; RdE = 5'd0;
        #1;
        chk("lu_clear", {29'd0, haz_act}, 32'd0);
        chk("lu_held_ctrl", {21'd0, ctrl_act}, {21'd0, mk(0,3'b001,0,0,1,0,0,2'b00)});
        chk("lu_held_rd", {27'd0, RdD}, 32'd4);
        chk("lu_held_pcd", PCD, 32'h0000_0300);
        tick();
        chk("lu_resume_rd", {27'd0, RdD}, 32'd5);
        chk("lu_resume_pcd", PCD, 32'h0000_0304);

        // ---------------- flush, with simultaneous load-use ----------------
        InstrF = I_BEQ_N8; PCF = 32'h0000_0400; PCPlus4F = 32'h0000_0404;
        tick();
        chk("fl_beq_ctrl", {21'd0, ctrl_act}, {21'd0, mk(0,3'b001,0,0,0,1,0,2'b00)});
        InstrF = I_ADDI_N3; PCF = 32'h0000_0404; PCPlus4F = 32'h0000_0408;
        PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd1;
        #1;
        chk("fl_haz", {29'd0, haz_act}, 32'd1);
        tick();
        PCSrcE = 1'b0; ResultSrcE = 2'b00; RdE = 5'd0;
        #1;
        chk("fl_ctrl0", {21'd0, ctrl_act}, 32'd0);
        chk("fl_imm0", ImmExtD, 32'd0);
        chk("fl_pcd_hold", PCD, 32'h0000_0400);
        chk("fl_haz_after", {29'd0, haz_act}, 32'd0);
        tick();
        chk("fl_resume_rd", {27'd0, RdD}, 32'd5);

        // ---------------- reset with illegal in ID ----------------
        InstrF = I_ILL7F;
        tick();
        chk("ill_set", {31'd0, IllegalD}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("ill_reset", {31'd0, IllegalD}, 32'd0);
        chk("ill_reset_pcd", PCD, RESET_PC);

        // ---------------- reset mid-stall, register contents lost ----------------
        InstrF = I_SUB;
        tick();
        ResultSrcE = 2'b01; RdE = 5'd3;
        #1;
        chk("ms_stall", {29'd0, haz_act}, 32'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("ms_cleared", {29'd0, haz_act}, 32'd0);
        ResultSrcE = 2'b00; RdE = 5'd0;
        InstrF = I_ADD_X7;
        tick();
        chk("regs_lost", RD1, 32'd0);
        chk("after_reset_rd", {27'd0, RdD}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage RV32I pipeline, between the fetch stage and the ID/EX pipeline register. It holds the IF/ID pipeline register (with stall and flush), the 32x32 register file with write-back bypass, the main/ALU control decoder and the immediate extender, and detects load-use hazards. Its D-suffixed outputs connect 1:1 to the ID/EX register inputs.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value of PCD/PCPlus4D-4 base after reset (PCD resets to RESET_PC, PCPlus4D to RESET_PC+4)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- InstrF, PCF, PCPlus4F  in  32 each  fetch-stage instruction, PC, PC+4
- PCSrcE  in  1  branch/jump taken in EX; flushes IF/ID and requests ID/EX flush
- RdE  in  5  destination of instruction in EX
- ResultSrcE  in  2  result select of instruction in EX (01 = load)
- RegWriteW  in  1  write-back enable
- RdW  in  5  write-back destination
- ResultW  in  32  write-back data
- RD1, RD2  out  32  register operands
- ImmExtD, PCD, PCPlus4D  out  32  extended immediate, PC, PC+4
- Rs1D, Rs2D, RdD  out  5  InstrD[19:15], [24:20], [11:7]
- ALUControlD  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ALUSrcD, MemWriteD, RegWriteD, BranchD, JumpD  out  1
- ResultSrcD  out  2  00 ALU, 01 memory, 10 PC+4
- StallF, StallD  out  1  hold PC / hold IF/ID
- FlushE  out  1  clear ID/EX
- IllegalD  out  1  valid instruction in ID is unsupported

## Operation
- IF/ID register (InstrD, PCD, PCPlus4D, ValidD). Per-cycle priority: reset > PCSrcE (flush: InstrD=0, ValidD=0, PCs hold) > StallD (hold all) > load (ValidD=1).
- Register file: x0 reads 0; write on posedge when RegWriteW && RdW!=0. Reads are combinational. Write-through bypass: if RegWriteW && RdW!=0 && RdW==Rs1D then RD1=ResultW. Same for RD2 with Rs2D. Reset clears all 32 registers.
- Decode, ValidD=1:
  - lw (0000011, funct3 010): ALUSrc 1, RegWrite 1, ResultSrc 01, add
  - sw (0100011, funct3 010): ALUSrc 1, MemWrite 1, add
  - R-type (0110011): RegWrite 1
  - I-ALU (0010011): ALUSrc 1, RegWrite 1
  - beq (1100011, funct3 000): Branch 1, sub
  - jal (1101111): Jump 1, RegWrite 1, ResultSrc 10, add
- R-type/I-ALU funct3 → ALUControl:
  - 000 → add (R-type with funct7[5]=1 → sub)
  - 010 → slt
  - 110 → or
  - 111 → and
  - any other funct3 → illegal
- Any other opcode/funct3 combination → IllegalD=1 and all control outputs 0. When ValidD=0: all controls 0, IllegalD=0.
- Immediates (all sign-extended from InstrD[31]): I {[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}. R-type gives ImmExtD=0.
- Load-use: lwStall = ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && ValidD. This is conservative; Rs2D is compared for every format.
- StallF = StallD = lwStall && !PCSrcE. FlushE = lwStall || PCSrcE.

## Timing
- InstrF is captured at edge N; its decoded outputs are valid combinationally during cycle N+1. Latency is 1 cycle.
- A register write at edge N is visible through the bypass during cycle N and from the array from cycle N+1 on.
- Reset values, held until the first load after reset deasserts:
  - InstrD = 0, ValidD = 0
  - all controls, ImmExtD, RD1, RD2, Rs/Rd fields = 0
  - PCD = RESET_PC, PCPlus4D = RESET_PC+4
  - StallF/StallD/FlushE = 0 (PCSrcE and RdE are driven 0 by the upstream reset)
- A load-use stall lasts exactly one cycle. The lw moves to MEM, ResultSrcE becomes 00, and the stall drops.
- Reset asserted mid-stall clears the stall on the next edge. Register contents are lost.
- PCSrcE and lwStall in the same cycle: the flush wins. IF/ID is cleared, no stall, FlushE=1.

## Test plan
- Reset, then load addi x5,x0,-3 (0xFFD00293) → next cycle: RegWriteD=1, ALUSrcD=1, ALUControlD=000, ImmExtD=0xFFFFFFFD, RdD=5.
- RegWriteW=1, RdW=7, ResultW=0xDEADBEEF in the same cycle that add x1,x7,x0 is in ID → RD1=0xDEADBEEF that cycle. RdW=0 write → x0 still reads 0.
- ResultSrcE=01, RdE=3 while sub x4,x3,x2 is in ID → StallF=StallD=FlushE=1 for one cycle, InstrD held. Next cycle (ResultSrcE=00) → stall clear.
- PCSrcE=1 with a valid beq in ID → next cycle all controls 0, ValidD=0, FlushE=1 in the flush cycle. Simultaneous lwStall → no stall.
- jal x1,+2048 (0x001000EF... encoded J-imm 0x800) → JumpD=1, ResultSrcD=10, ImmExtD=0x00000800. beq with negative offset −8 → ImmExtD=0xFFFFFFF8, ALUControlD=001.
- Opcode 0x7F or R-type funct3 001 → IllegalD=1 and all controls 0. Assert reset while an illegal instruction is in ID → IllegalD=0 the next cycle.
